// File: rtl/mem_rd_arbiter.sv
// Round-robin arbiter sharing one 8-bit-address read port among NUM_REQ clients.
// One read in flight at a time; a silent memory is aborted after TIMEOUT cycles.
module mem_rd_arbiter #(
  parameter int WIDTH   = 16,
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NUM_REQ-1:0]   rq_read,
  input  logic [NUM_REQ*8-1:0] rq_addr,
  output logic [WIDTH-1:0]     rq_data,
  output logic [NUM_REQ-1:0]   rq_valid,
  output logic                 rq_err,
  output logic [7:0]           mem_addr,
  output logic                 mem_read,
  input  logic [WIDTH-1:0]     mem_data,
  input  logic                 mem_valid,
  output logic                 busy
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [IW-1:0] PTR_RST = IW'(NUM_REQ - 1);
  localparam logic [CW-1:0] TO_LIM  = CW'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_e;

  state_e state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] gnt_q, gnt_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0] mem_addr_q, mem_addr_d;
  logic mem_read_q, mem_read_d;
  logic [WIDTH-1:0] rq_data_q, rq_data_d;
  logic [NUM_REQ-1:0] rq_valid_q, rq_valid_d;
  logic rq_err_q, rq_err_d;
  logic busy_q, busy_d;

  logic pick_ok;
  logic [IW-1:0] pick;

  // First requester after the last one served, wrapping around.
  always_comb begin
    pick_ok = 1'b0;
    pick = ptr_q;
    for (int i = 1; i <= NUM_REQ; i++) begin
      if (!pick_ok &&
          rq_read[IW'((int'(ptr_q) + i) % NUM_REQ)]) begin
        pick_ok = 1'b1;
        pick = IW'((int'(ptr_q) + i) % NUM_REQ);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    gnt_d = gnt_q;
    cnt_d = cnt_q;
    mem_addr_d = mem_addr_q;
    rq_data_d = rq_data_q;
    rq_err_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pick_ok) begin
          state_d = ISSUE;
          gnt_d = pick;
          mem_addr_d = rq_addr[8*int'(pick) +: 8];
        end
      end
      ISSUE: begin
        state_d = WAIT;
        if (mem_valid) begin
          state_d = RESP;
          rq_data_d = mem_data;
        end
      end
      WAIT: begin
        if (mem_valid) begin
          state_d = RESP;
          rq_data_d = mem_data;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (TIMEOUT != 0 && cnt_d == TO_LIM) begin
            state_d = RESP;
            rq_data_d = '0;
            rq_err_d = 1'b1;
          end
        end
      end
      RESP: begin
        state_d = IDLE;
        ptr_d = gnt_q;
        cnt_d = '0;
      end
      default: state_d = IDLE;
    endcase

    // Outputs are registered, so they follow the next state.
    mem_read_d = (state_d == ISSUE);
    busy_d = (state_d != IDLE);
    rq_valid_d = '0;
    if (state_d == RESP) rq_valid_d[gnt_d] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      ptr_q <= PTR_RST;
      gnt_q <= '0;
      cnt_q <= '0;
      mem_addr_q <= '0;
      mem_read_q <= 1'b0;
      rq_data_q <= '0;
      rq_valid_q <= '0;
      rq_err_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      gnt_q <= gnt_d;
      cnt_q <= cnt_d;
      mem_addr_q <= mem_addr_d;
      mem_read_q <= mem_read_d;
      rq_data_q <= rq_data_d;
      rq_valid_q <= rq_valid_d;
      rq_err_q <= rq_err_d;
      busy_q <= busy_d;
    end
  end

  assign mem_addr = mem_addr_q;
  assign mem_read = mem_read_q;
  assign rq_data = rq_data_q;
  assign rq_valid = rq_valid_q;
  assign rq_err = rq_err_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_mem_rd_arbiter.sv
// Bench for mem_rd_arbiter: timestamp-based transaction model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_mem_rd_arbiter;

  localparam int WIDTH = 16;
  localparam int NUM_REQ = 4;
  localparam int TIMEOUT = 64;

  logic clk = 1'b0;
  logic reset_n;
  logic [NUM_REQ-1:0] rq_read;
  logic [NUM_REQ*8-1:0] rq_addr;
  logic [WIDTH-1:0] rq_data;
  logic [NUM_REQ-1:0] rq_valid;
  logic rq_err;
  logic [7:0] mem_addr;
  logic mem_read;
  logic [WIDTH-1:0] mem_data;
  logic mem_valid;
  logic busy;

  int n_tests = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mem_rd_arbiter #(
    .WIDTH(WIDTH),
    .NUM_REQ(NUM_REQ),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .rq_read(rq_read),
    .rq_addr(rq_addr),
    .rq_data(rq_data),
    .rq_valid(rq_valid),
    .rq_err(rq_err),
    .mem_addr(mem_addr),
    .mem_read(mem_read),
    .mem_data(mem_data),
    .mem_valid(mem_valid),
    .busy(busy)
  );

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t got=%0h exp=%0h", nm, $time, act, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] mem_word(logic [7:0] a);
    if (a == 8'h12) return 16'hBEEF;
    return {a ^ 8'hA5, a};
  endfunction

  function automatic int rr_pick(int p, logic [NUM_REQ-1:0] r);
    for (int k = 1; k <= NUM_REQ; k++)
      if (r[(p + k) % NUM_REQ]) return (p + k) % NUM_REQ;
    return -1;
  endfunction

  // Model: a transaction is a grant plus strobe and response timestamps.
  int m_ptr, m_gnt, m_now, m_tiss, m_tresp;
  bit m_act, m_err;
  logic [WIDTH-1:0] m_data;
  logic [7:0] m_addr;
  logic [NUM_REQ-1:0] exp_valid;
  int resp_q[$];

  initial begin
    m_ptr = NUM_REQ - 1;
    m_act = 0;
    m_err = 0;
    m_gnt = 0;
    m_tiss = -1;
    m_tresp = -1;
    m_data = '0;
    m_addr = '0;
    m_now = 0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        m_ptr = NUM_REQ - 1;
        m_act = 0;
        m_err = 0;
        m_data = '0;
        m_addr = '0;
        m_tresp = -1;
      end
      exp_valid = '0;
      if (m_act && m_now == m_tresp) exp_valid[m_gnt] = 1'b1;
      chk("mem_read", mem_read, m_act && m_now == m_tiss);
      chk("mem_addr", mem_addr, m_addr);
      chk("busy", busy, m_act);
      chk("rq_valid", rq_valid, exp_valid);
      chk("rq_err", rq_err, (exp_valid != 0) && m_err);
      chk("rq_data", rq_data, m_data);
      chk("onehot", $countones(rq_valid) <= 1, 1);
      for (int k = 0; k < NUM_REQ; k++)
        if (rq_valid[k]) resp_q.push_back(k);
      if (reset_n) begin
        if (m_act) begin
          if (m_now == m_tresp) begin
            m_ptr = m_gnt;
            m_act = 0;
          end else if (m_tresp < 0) begin
            if (mem_valid) begin
              m_tresp = m_now + 1;
              m_data = mem_data;
              m_err = 0;
            end else if (TIMEOUT != 0 &&
                         m_now + 1 == m_tiss + 1 + TIMEOUT) begin
              m_tresp = m_now + 1;
              m_data = '0;
              m_err = 1;
            end
          end
        end else if (rq_read != 0) begin
          m_gnt = rr_pick(m_ptr, rq_read);
          m_addr = rq_addr[8*m_gnt +: 8];
          m_act = 1;
          m_tiss = m_now + 1;
          m_tresp = -1;
        end
      end
      m_now++;
    end
  end

  // Memory responder and requester drop, stepped once per cycle.
  bit auto_en = 0;
  int lat = 0;
  int pend = -1;
  bit man_pulse = 0;
  logic [WIDTH-1:0] man_data = '0;

  task automatic tick();
    @(posedge clk);
    #1;
    mem_valid = 1'b0;
    if (man_pulse) begin
      mem_valid = 1'b1;
      mem_data = man_data;
      man_pulse = 0;
    end
    if (auto_en && mem_read) pend = lat;
    else if (pend > 0) pend--;
    if (pend == 0) begin
      mem_valid = 1'b1;
      mem_data = mem_word(mem_addr);
      pend = -1;
    end
    rq_read = rq_read & ~rq_valid;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    rq_read = '0;
    rq_addr = '0;
    auto_en = 0;
    pend = -1;
    man_pulse = 0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  task automatic wait_idle(int lim);
    bit done = 0;
    for (int i = 0; i < lim && !done; i++) begin
      tick();
      if (rq_read == 0 && !busy) done = 1;
    end
    chk("wait_idle", done, 1);
  endtask

  function automatic int q_at(int i);
    if (i < resp_q.size()) return resp_q[i];
    return -1;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    rq_read = '0;
    rq_addr = '0;
    mem_data = '0;
    mem_valid = 1'b0;
    tick();
    tick();
    chk("rst_busy", busy, 0);
    chk("rst_valid", rq_valid, 0);
    chk("rst_mem_read", mem_read, 0);
    chk("rst_data", rq_data, 0);

    // Basic read, memory answers 3 cycles after the strobe
    reset_n = 1'b1;
    rq_addr[7:0] = 8'h12;
    rq_read = 4'b0001;
    auto_en = 1;
    lat = 3;
    tick();
    chk("t1_strobe", mem_read, 1);
    chk("t1_addr", mem_addr, 8'h12);
    chk("t1_busy", busy, 1);
    repeat (4) tick();
    chk("t1_valid", rq_valid, 4'b0001);
    chk("t1_data", rq_data, 16'hBEEF);
    chk("t1_err", rq_err, 0);
    chk("t1_busy5", busy, 1);
    tick();
    chk("t1_idle", busy, 0);

    // Round-robin order
    do_reset();
    rq_addr[7:0] = 8'h10;
    rq_addr[15:8] = 8'h11;
    rq_addr[23:16] = 8'h12;
    resp_q.delete();
    auto_en = 1;
    lat = 1;
    rq_read = 4'b0111;
    wait_idle(60);
    chk("t2_n", resp_q.size(), 3);
    chk("t2_g0", q_at(0), 0);
    chk("t2_g1", q_at(1), 1);
    chk("t2_g2", q_at(2), 2);
    resp_q.delete();
    rq_read = 4'b0101;
    wait_idle(60);
    chk("t2b_n", resp_q.size(), 2);
    chk("t2b_g0", q_at(0), 0);
    chk("t2b_g1", q_at(1), 2);

    // Stray mem_valid while idle
    do_reset();
    man_data = 16'h1234;
    man_pulse = 1;
    tick();
    chk("t4_idle_busy", busy, 0);
    chk("t4_idle_valid", rq_valid, 0);
    tick();
    chk("t4_idle_valid2", rq_valid, 0);
    chk("t4_idle_data", rq_data, 0);

    // Normal read, then a timeout
    rq_addr[7:0] = 8'h12;
    rq_read = 4'b0001;
    auto_en = 1;
    lat = 2;
    wait_idle(20);
    chk("t3_pre_data", rq_data, 16'hBEEF);
    auto_en = 0;
    rq_addr[15:8] = 8'h40;
    rq_read = 4'b0010;
    repeat (65) tick();
    chk("t3_no_early", rq_valid, 0);
    chk("t3_busy", busy, 1);
    tick();
    chk("t3_valid", rq_valid, 4'b0010);
    chk("t3_err", rq_err, 1);
    chk("t3_data", rq_data, 0);
    man_data = 16'h5555;
    man_pulse = 1;
    tick();
    chk("t4_late_valid", rq_valid, 0);
    chk("t4_late_busy", busy, 0);
    tick();
    chk("t4_late_valid2", rq_valid, 0);
    chk("t4_late_err", rq_err, 0);
    chk("t4_late_data", rq_data, 0);
    resp_q.delete();
    rq_addr[23:16] = 8'h12;
    rq_read = 4'b0100;
    auto_en = 1;
    lat = 2;
    wait_idle(20);
    chk("t3_next_idx", q_at(0), 2);
    chk("t3_next_data", rq_data, 16'hBEEF);

    // Reset during WAIT
    do_reset();
    rq_addr[15:8] = 8'h21;
    rq_read = 4'b0010;
    auto_en = 0;
    repeat (3) tick();
    chk("t5_wait_busy", busy, 1);
    reset_n = 1'b0;
    rq_read = '0;
    #1;
    chk("t5_async_busy", busy, 0);
    man_data = 16'h7777;
    man_pulse = 1;
    tick();
    chk("t5_no_valid", rq_valid, 0);
    chk("t5_busy", busy, 0);
    reset_n = 1'b1;
    rq_addr[31:24] = 8'h12;
    rq_read = 4'b1000;
    auto_en = 1;
    lat = 1;
    resp_q.delete();
    wait_idle(20);
    chk("t5_idx", q_at(0), 3);
    chk("t5_data", rq_data, 16'hBEEF);

    // Zero-wait memory
    do_reset();
    rq_addr[23:16] = 8'h33;
    rq_read = 4'b0100;
    auto_en = 1;
    lat = 0;
    tick();
    chk("t6_strobe", mem_read, 1);
    tick();
    chk("t6_valid", rq_valid, 4'b0100);
    chk("t6_data", rq_data, 16'h9633);
    chk("t6_err", rq_err, 0);
    tick();
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
